// File: rtl/restore_div_seq.sv
// Iterative restoring divider: one quotient bit per clock through a single
// WIDTH+1-bit subtract/restore stage, with signed mode and error flags.
module restore_div_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_reg;
  logic [CW-1:0]    cnt_reg;
  // Partial remainder is always < |D| after restore, so WIDTH bits hold it;
  // the extra bit only exists transiently in shift_w/trial_w.
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] n_reg;
  logic             sign_q_reg;
  logic             sign_r_reg;
  logic             dz_reg;
  logic             ovf_reg;

  logic [WIDTH:0]   shift_w;
  logic [WIDTH:0]   trial_w;
  logic [WIDTH-1:0] n_mag_w;
  logic [WIDTH-1:0] d_mag_w;
  logic [WIDTH-1:0] q_fix_w;
  logic [WIDTH-1:0] r_fix_w;

  always_comb begin
    n_mag_w = (signed_op && dividend[WIDTH-1]) ? ('0 - dividend) : dividend;
    d_mag_w = (signed_op && divisor[WIDTH-1])  ? ('0 - divisor)  : divisor;
    shift_w = {p_reg, a_reg[WIDTH-1]};
    trial_w = shift_w - {1'b0, d_reg};
    q_fix_w = sign_q_reg ? ('0 - a_reg) : a_reg;
    r_fix_w = sign_r_reg ? ('0 - p_reg) : p_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      p_reg       <= '0;
      a_reg       <= '0;
      d_reg       <= '0;
      n_reg       <= '0;
      sign_q_reg  <= 1'b0;
      sign_r_reg  <= 1'b0;
      dz_reg      <= 1'b0;
      ovf_reg     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg      <= n_mag_w;
            d_reg      <= d_mag_w;
            n_reg      <= dividend;
            sign_q_reg <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            sign_r_reg <= signed_op & dividend[WIDTH-1];
            dz_reg     <= (divisor == '0);
            ovf_reg    <= signed_op && (dividend == MOST_NEG) && (divisor == '1);
            p_reg      <= '0;
            cnt_reg    <= CW'(WIDTH - 1);
            busy       <= 1'b1;
            state_reg  <= RUN;
          end
        end
        RUN: begin
          if (!trial_w[WIDTH]) begin
            p_reg <= trial_w[WIDTH-1:0];
            a_reg <= {a_reg[WIDTH-2:0], 1'b1};
          end else begin
            p_reg <= shift_w[WIDTH-1:0];
            a_reg <= {a_reg[WIDTH-2:0], 1'b0};
          end
          if (cnt_reg == '0) begin
            state_reg <= FIX;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        FIX: begin
          // Error cases override the sign-corrected iteration result.
          if (dz_reg) begin
            quotient    <= '1;
            remainder   <= n_reg;
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
          end else if (ovf_reg) begin
            quotient    <= MOST_NEG;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b1;
          end else begin
            quotient    <= q_fix_w;
            remainder   <= r_fix_w;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
          end
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
